// File: rtl/syn_update_sched.sv
// syn_update_sched: sweeps synaptic SRAM words as RMW pairs and slots host SPI accesses between the pairs.
// Ports: CLK/RSTN; START_UPDATE/IS_TRAIN launch a sweep; PRE_NEUR_S_CNT gates zero-spike skipping;
// SPI_REQ/SPI_WE/SPI_ADDR/SPI_BYTE -> SPI_ACK host access; CTRL_SYNARRAY_* drive the SRAM;
// CTRL_PRE/POST_NEURON_ADDRESS, CTRL_SYNA_RD/WR_EVENT, SPI_GATE steer the datapath; BUSY/DONE report the sweep.
// Optional: define SYN_SKIP_ZERO_PRE_EN to add a PRE_CHK state that skips pre-neurons with no spikes.
module syn_update_sched #(
  parameter int N = 784,
  parameter int M = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START_UPDATE,
  input  logic              IS_TRAIN,
  input  logic [7:0]        PRE_NEUR_S_CNT,
  input  logic              SPI_REQ,
  input  logic              SPI_WE,
  input  logic [ADDR_W-1:0] SPI_ADDR,
  input  logic [1:0]        SPI_BYTE,
  output logic              SPI_ACK,
  output logic              CTRL_SYNARRAY_CS,
  output logic              CTRL_SYNARRAY_WE,
  output logic [ADDR_W-1:0] CTRL_SYNARRAY_ADDR,
  output logic [9:0]        CTRL_PRE_NEURON_ADDRESS,
  output logic [9:0]        CTRL_POST_NEURON_ADDRESS,
  output logic              CTRL_SYNA_RD_EVENT,
  output logic              CTRL_SYNA_WR_EVENT,
  output logic              SPI_GATE,
  output logic              BUSY,
  output logic              DONE
);
  localparam int WORDS = (M + 3) / 4;
  localparam int WI_W = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [2:0] {IDLE, UPD_RD, UPD_WR, SPI_RD, SPI_WR, PRE_CHK} state_t;
`ifdef SYN_SKIP_ZERO_PRE_EN
  localparam state_t FIRST = PRE_CHK;
`else
  localparam state_t FIRST = UPD_RD;
`endif
  state_t            state;
  logic [9:0]        pre_idx;
  logic [WI_W-1:0]   word_idx;
  logic [ADDR_W-1:0] addr;
  logic              busy, done;
  logic              spi_we_q;
  logic [1:0]        spi_byte_q;
  logic [ADDR_W-1:0] spi_addr_q;
  logic              last_word, last_pre, upd, spi;
  assign last_word = word_idx == WI_W'(WORDS - 1);
  assign last_pre  = pre_idx == 10'(N - 1);
  // Host request fields are captured on entry so outputs depend on registers only.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      pre_idx    <= '0;
      word_idx   <= '0;
      addr       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_we_q   <= 1'b0;
      spi_byte_q <= '0;
      spi_addr_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (SPI_REQ) begin
            state      <= SPI_RD;
            spi_we_q   <= SPI_WE;
            spi_byte_q <= SPI_BYTE;
            spi_addr_q <= SPI_ADDR;
          end else if (START_UPDATE) begin
            if (IS_TRAIN) begin
              state    <= FIRST;
              busy     <= 1'b1;
              pre_idx  <= '0;
              word_idx <= '0;
              addr     <= '0;
            end else done <= 1'b1;
          end
        PRE_CHK:
          if (PRE_NEUR_S_CNT == 8'd0) begin
            addr <= addr + ADDR_W'(WORDS);
            if (last_pre) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else pre_idx <= pre_idx + 10'd1;
          end else state <= UPD_RD;
        UPD_RD: state <= UPD_WR;
        UPD_WR:
          if (last_pre && last_word) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            word_idx <= last_word ? '0 : word_idx + WI_W'(1);
            if (last_word) pre_idx <= pre_idx + 10'd1;
            addr <= addr + ADDR_W'(1);
            if (SPI_REQ) begin
              state      <= SPI_RD;
              spi_we_q   <= SPI_WE;
              spi_byte_q <= SPI_BYTE;
              spi_addr_q <= SPI_ADDR;
            end else state <= last_word ? FIRST : UPD_RD;
          end
        SPI_RD: state <= SPI_WR;
        SPI_WR: state <= busy ? (word_idx == '0 ? FIRST : UPD_RD) : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign upd = state == UPD_RD || state == UPD_WR;
  assign spi = state == SPI_RD || state == SPI_WR;
  always_comb begin
    CTRL_SYNARRAY_CS         = upd || state == SPI_RD || (state == SPI_WR && spi_we_q);
    CTRL_SYNARRAY_WE         = state == UPD_WR || (state == SPI_WR && spi_we_q);
    CTRL_SYNARRAY_ADDR       = spi ? spi_addr_q : upd ? addr : '0;
    CTRL_PRE_NEURON_ADDRESS  = pre_idx;
    CTRL_POST_NEURON_ADDRESS = spi ? 10'(spi_byte_q) : busy ? 10'({word_idx, 2'b00}) : 10'd0;
    CTRL_SYNA_RD_EVENT       = state == SPI_RD || (state == SPI_WR && !spi_we_q);
    CTRL_SYNA_WR_EVENT       = state == SPI_WR && spi_we_q;
    SPI_GATE                 = spi;
    SPI_ACK                  = state == SPI_WR;
    BUSY                     = busy;
    DONE                     = done;
  end
endmodule

// File: tb/tb_syn_update_sched.sv
// tb_syn_update_sched: scoreboard bench for syn_update_sched at N=4, M=8.
module tb_syn_update_sched;
  localparam int N = 4, M = 8, AW = 16, W = (M + 3) / 4;
`ifdef SYN_SKIP_ZERO_PRE_EN
  localparam int PC = 1;
`else
  localparam int PC = 0;
`endif
  logic CLK, RSTN, START_UPDATE, IS_TRAIN, SPI_REQ, SPI_WE, SPI_ACK;
  logic [7:0] PRE_NEUR_S_CNT;
  logic [AW-1:0] SPI_ADDR, CTRL_SYNARRAY_ADDR;
  logic [1:0] SPI_BYTE;
  logic CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNA_RD_EVENT, CTRL_SYNA_WR_EVENT, SPI_GATE, BUSY, DONE;
  logic [9:0] CTRL_PRE_NEURON_ADDRESS, CTRL_POST_NEURON_ADDRESS;
  int zero_pre = -1;
  assign PRE_NEUR_S_CNT = (int'(CTRL_PRE_NEURON_ADDRESS) == zero_pre) ? 8'd0 : 8'd3;
  syn_update_sched #(.N(N), .M(M), .ADDR_W(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .START_UPDATE(START_UPDATE), .IS_TRAIN(IS_TRAIN),
    .PRE_NEUR_S_CNT(PRE_NEUR_S_CNT), .SPI_REQ(SPI_REQ), .SPI_WE(SPI_WE), .SPI_ADDR(SPI_ADDR),
    .SPI_BYTE(SPI_BYTE), .SPI_ACK(SPI_ACK), .CTRL_SYNARRAY_CS(CTRL_SYNARRAY_CS),
    .CTRL_SYNARRAY_WE(CTRL_SYNARRAY_WE), .CTRL_SYNARRAY_ADDR(CTRL_SYNARRAY_ADDR),
    .CTRL_PRE_NEURON_ADDRESS(CTRL_PRE_NEURON_ADDRESS), .CTRL_POST_NEURON_ADDRESS(CTRL_POST_NEURON_ADDRESS),
    .CTRL_SYNA_RD_EVENT(CTRL_SYNA_RD_EVENT), .CTRL_SYNA_WR_EVENT(CTRL_SYNA_WR_EVENT),
    .SPI_GATE(SPI_GATE), .BUSY(BUSY), .DONE(DONE)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  int tests = 0, fails = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [9:0] post;} acc_t;
  acc_t q[$];
  acc_t mon_g, mon_e;
  task automatic push(input logic we, input int a, input int post);
    acc_t e;
    e.we = we;
    e.addr = AW'(a);
    e.post = 10'(post);
    q.push_back(e);
  endtask
  task automatic push_pair(input int a);
    push(1'b0, a, (a % W) * 4);
    push(1'b1, a, (a % W) * 4);
  endtask
  // Every SRAM access the DUT issues must match the next expected one.
  always @(negedge CLK)
    if (RSTN && CTRL_SYNARRAY_CS) begin
      mon_g = '{CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_POST_NEURON_ADDRESS};
      chk("access_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("access", mon_g, mon_e);
      end
    end
  function automatic logic [63:0] outs();
    return {CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_NEURON_ADDRESS,
            CTRL_POST_NEURON_ADDRESS, CTRL_SYNA_RD_EVENT, CTRL_SYNA_WR_EVENT, SPI_GATE, SPI_ACK, BUSY, DONE};
  endfunction
  task automatic sweep(input bit spi, output int nd, output int na);
    bit req = 0;
    nd = -1;
    na = -1;
    @(negedge CLK);
    START_UPDATE = 1;
    IS_TRAIN = 1;
    for (int n = 1; n <= 6000; n++) begin
      @(negedge CLK);
      START_UPDATE = 0;
      if (n == 1) chk("busy_start", BUSY, 1);
      if (spi && !req && CTRL_SYNARRAY_CS && !CTRL_SYNARRAY_WE && !SPI_GATE && CTRL_SYNARRAY_ADDR == 1) begin
        SPI_REQ = 1;
        SPI_WE = 1;
        SPI_ADDR = 5;
        SPI_BYTE = 2;
        req = 1;
      end
      if (SPI_ACK) begin
        na = n;
        chk("spi_wr_event", CTRL_SYNA_WR_EVENT, 1);
        chk("spi_gate", SPI_GATE, 1);
        SPI_REQ = 0;
      end
      if (DONE) begin
        nd = n;
        break;
      end
    end
    chk("sweep_done_seen", nd >= 0, 1);
    chk("busy_after", BUSY, 0);
    chk("queue_empty", q.size(), 0);
  endtask
  int nd, na, dones;
  initial begin
    RSTN = 0; START_UPDATE = 0; IS_TRAIN = 0; SPI_REQ = 0; SPI_WE = 0; SPI_ADDR = 0; SPI_BYTE = 0;
    #12;
    chk("reset_outs", outs(), 0);
    @(negedge CLK);
    RSTN = 1;
    // Plain sweep
    for (int a = 0; a < N * W; a++) push_pair(a);
    sweep(0, nd, na);
    chk("sweep_len", nd, 2 * N * W + PC * N + 1);
    @(negedge CLK);
    chk("done_pulse", DONE, 0);
    // IS_TRAIN=0: DONE only, no access
    START_UPDATE = 1;
    IS_TRAIN = 0;
    @(negedge CLK);
    START_UPDATE = 0;
    chk("notrain_done", DONE, 1);
    chk("notrain_busy", BUSY, 0);
    @(negedge CLK);
    chk("notrain_done_end", DONE, 0);
    // SPI byte write mid-sweep
    push_pair(0);
    push_pair(1);
    push(1'b0, 5, 2);
    push(1'b1, 5, 2);
    for (int a = 2; a < N * W; a++) push_pair(a);
    sweep(1, nd, na);
    chk("spi_ack_cycle", na, 6 + PC);
    chk("spi_sweep_len", nd, 2 * N * W + PC * N + 3);
    // SPI read in idle
    @(negedge CLK);
    SPI_REQ = 1;
    SPI_WE = 0;
    SPI_ADDR = 3;
    SPI_BYTE = 1;
    push(1'b0, 3, 1);
    @(negedge CLK);
    chk("rd1_event", CTRL_SYNA_RD_EVENT, 1);
    chk("rd1_gate", SPI_GATE, 1);
    chk("rd1_ack", SPI_ACK, 0);
    @(negedge CLK);
    chk("rd2_ack", SPI_ACK, 1);
    chk("rd2_cs", CTRL_SYNARRAY_CS, 0);
    chk("rd2_event", CTRL_SYNA_RD_EVENT, 1);
    chk("rd2_wr_event", CTRL_SYNA_WR_EVENT, 0);
    SPI_REQ = 0;
    @(negedge CLK);
    chk("rd3_ack", SPI_ACK, 0);
    chk("rd3_gate", SPI_GATE, 0);
    chk("rd_queue", q.size(), 0);
    // Reset during UPD_RD of address 6
    for (int a = 0; a < 6; a++) push_pair(a);
    push(1'b0, 6, 0);
    START_UPDATE = 1;
    IS_TRAIN = 1;
    nd = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      START_UPDATE = 0;
      if (CTRL_SYNARRAY_CS && !CTRL_SYNARRAY_WE && CTRL_SYNARRAY_ADDR == 6) begin
        nd = 1;
        break;
      end
    end
    chk("rst_reach_addr6", nd, 1);
    #1 RSTN = 0;
    #1 chk("rst_mid_outs", outs(), 0);
    chk("rst_mid_queue", q.size(), 0);
    @(negedge CLK);
    RSTN = 1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_idle_outs", outs(), 0);
`ifdef SYN_SKIP_ZERO_PRE_EN
    // Pre-neuron 1 has no spikes: its words are skipped
    zero_pre = 1;
    for (int a = 0; a < N * W; a++) if (a / W != 1) push_pair(a);
    sweep(0, nd, na);
    chk("skip_len", nd, 17);
    zero_pre = -1;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/syn_update_sched.md
Name: syn_update_sched

Overview:
Sequencer for the synaptic SRAM and weight-update datapath. On a training trigger it sweeps every (pre-neuron, post-word) SRAM word as a read-modify-write pair: read the word, then write back the updated weights produced combinationally by the update datapath. It also arbitrates host (SPI) byte programming and readback into the gaps between sweep RMW pairs, so a single owner drives the SRAM CS/WE/ADDR.

Parameters:
N, 784, number of pre-synaptic neurons.
M, 8, number of post-synaptic neurons; WORDS = ceil(M/4) 32-bit words per pre-neuron, 4 weights per word.
ADDR_W, 16, SRAM word-address width.

Ports:
CLK  in  1  clock, all state on rising edge
RSTN  in  1  asynchronous active-low reset
START_UPDATE  in  1  one-cycle pulse, begin weight-update sweep
IS_TRAIN  in  1  sampled at START_UPDATE; 0 = no sweep
PRE_NEUR_S_CNT  in  8  spike count of pre-neuron at CTRL_PRE_NEURON_ADDRESS (used only with the optional feature)
SPI_REQ  in  1  host access request, held until SPI_ACK
SPI_WE  in  1  1 = byte write, 0 = word read
SPI_ADDR  in  ADDR_W  host word address
SPI_BYTE  in  2  target byte within the word for a write
SPI_ACK  out  1  one-cycle completion pulse; for reads, SRAM rdata is valid in this cycle
CTRL_SYNARRAY_CS  out  1  SRAM chip select
CTRL_SYNARRAY_WE  out  1  SRAM write enable
CTRL_SYNARRAY_ADDR  out  ADDR_W  SRAM word address
CTRL_PRE_NEURON_ADDRESS  out  10  pre-neuron index of the current sweep word
CTRL_POST_NEURON_ADDRESS  out  10  post byte select: word_idx*4 during the sweep, SPI_BYTE during SPI access
CTRL_SYNA_RD_EVENT  out  1  high in SPI read cycles
CTRL_SYNA_WR_EVENT  out  1  high in the SPI write-back cycle
SPI_GATE  out  1  1 during SPI states (selects programming data path), 0 otherwise
BUSY  out  1  sweep in progress
DONE  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE, pre_idx = 0, word_idx = 0, addr = 0; every output 0. Reset mid-sweep or mid-SPI abandons the operation with no further write, and no DONE or SPI_ACK is issued.
- States: IDLE, UPD_RD, UPD_WR, SPI_RD, SPI_WR. Outputs are decoded from registered state and counters only; there are no combinational paths from inputs to outputs.
- IDLE:
  - SPI_REQ has priority and moves to SPI_RD.
  - Otherwise, START_UPDATE with IS_TRAIN=1 moves to UPD_RD with counters cleared and BUSY set.
  - START_UPDATE with IS_TRAIN=0 pulses DONE in the next cycle and issues no SRAM access.
- UPD_RD: CS=1, WE=0, ADDR=addr. Always moves to UPD_WR.
- UPD_WR: CS=1, WE=1, same ADDR. SRAM rdata is valid this cycle and the update datapath output is written back. Then:
  - If the word just written is the last (pre_idx=N-1, word_idx=WORDS-1): go to IDLE, clear BUSY, pulse DONE in the following cycle.
  - Otherwise advance word_idx; on wrap to 0, increment pre_idx. Increment addr by 1. The address is maintained as a running counter; no multiplier.
  - Next state is SPI_RD if SPI_REQ is high, else UPD_RD.
- SPI_RD: CS=1, WE=0, ADDR=SPI_ADDR, SPI_GATE=1, CTRL_SYNA_RD_EVENT=1.
- SPI_WR: SPI_GATE=1, SPI_ACK=1.
  - Write (SPI_WE=1): CS=1, WE=1, CTRL_SYNA_WR_EVENT=1. This is a byte RMW; the selected byte is replaced and the other bytes are rewritten from rdata.
  - Read: CS=0, CTRL_SYNA_RD_EVENT=1.
  - Returns to UPD_RD if BUSY, else IDLE. Sweep counters are untouched by SPI accesses.
- An SPI access never splits a sweep RMW pair. At most one SPI access is serviced between consecutive pairs.
- START_UPDATE while BUSY, or while in an SPI state, is ignored.
- Sweep length without SPI traffic: 2*N*WORDS cycles (3136 at defaults). DONE follows exactly one cycle after the last UPD_WR.

Optional Feature:
Macro SYN_SKIP_ZERO_PRE_EN.
- Defined: a PRE_CHK state precedes the first word of each pre-neuron, with CS=0 and CTRL_PRE_NEURON_ADDRESS=pre_idx. If PRE_NEUR_S_CNT==0, all WORDS words of that pre-neuron are skipped: addr += WORDS and pre_idx is incremented. If the skipped pre-neuron is the last, the sweep ends and DONE follows. Otherwise PRE_CHK moves to UPD_RD.
- Undefined: no PRE_CHK state and every word is updated unconditionally.

Test Plan:
- Reset, then START_UPDATE with IS_TRAIN=1, N=4, M=8 -> 16 cycles of alternating RD/WR; ADDR sequence 0,0,1,1,…,7,7; CTRL_POST_NEURON_ADDRESS alternates 0,4; DONE at cycle 17; BUSY then drops.
- START_UPDATE with IS_TRAIN=0 -> no CS activity; DONE pulses 1 cycle later.
- SPI_REQ write, ADDR=0x0005, byte 2, mid-sweep -> completes after the current UPD_WR; SPI_RD then SPI_WR with WR_EVENT=1, ADDR=5, POST address 2; sweep resumes at the next address; total sweep length increases by 2 cycles.
- SPI read in IDLE, ADDR=0x0003 -> SPI_ACK on the 2nd cycle with CS=0; rdata equals the preloaded word.
- RSTN low during UPD_RD at addr 6 -> all outputs 0 immediately; no write to addr 6; no DONE.
- With SYN_SKIP_ZERO_PRE_EN, PRE_NEUR_S_CNT=0 for pre 1 (N=4) -> addrs 2,3 never accessed; DONE after 4 PRE_CHK + 12 RMW cycles.
